// File: rtl/irq_source_ctrl.sv
// -----------------------------------------------------------------------------
// irq_source_ctrl
//
// Collects edge-triggered interrupt requests from N_SRC level source lines,
// holds them in a pending register, filters them through a mask register and
// dispatches the lowest-numbered enabled source to the CPU as a fixed-length
// ir_req pulse. After dispatch the controller waits for ERET, then keeps
// ir_req low for a recovery gap before it can dispatch again.
//
// Ports
//   clk         main clock, all state updates on the rising edge
//   rst         synchronous reset, active low
//   src_irq     level source lines; a 0->1 transition is a request
//   mask_we     load mask_wdata into the mask register
//   mask_wdata  new mask value (1 = source enabled)
//   clr_we      apply clr_data as write-1-to-clear on pending
//   clr_data    pending bits to clear
//   eret        one-cycle pulse when the CPU executes ERET
//   ir_req      registered interrupt request to the CPU
//   cause_id    index of the source being serviced
//   pending     pending register
//   mask        mask register
//   busy        high whenever the controller is not idle
// -----------------------------------------------------------------------------
module irq_source_ctrl #(
  parameter int N_SRC     = 4,
  parameter int PULSE_LEN = 4,
  parameter int MIN_LOW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_irq,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             clr_we,
  input  logic [N_SRC-1:0] clr_data,
  input  logic             eret,
  output logic             ir_req,
  output logic [2:0]       cause_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask,
  output logic             busy
);

  // Controller states.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  // One counter width covers both the pulse and the recovery gap.
  localparam int CNT_W = (PULSE_LEN > MIN_LOW) ? $clog2(PULSE_LEN) + 1
                                                : $clog2(MIN_LOW) + 1;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(MIN_LOW - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [N_SRC-1:0] SRC_ZERO = {N_SRC{1'b0}};
  localparam logic [N_SRC-1:0] SRC_ONES = {N_SRC{1'b1}};
  localparam logic [N_SRC-1:0] SRC_LSB  = {{(N_SRC-1){1'b0}}, 1'b1};

  // Priority encoder: lowest set index, 0 when nothing is set.
  function automatic logic [2:0] lowest_idx(input logic [N_SRC-1:0] vec);
    logic [2:0] idx;
    logic       found;
    idx   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (vec[i] && !found) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Registered state.
  logic [1:0]       state_r;
  logic [CNT_W-1:0] pulse_cnt_r;
  logic [CNT_W-1:0] low_cnt_r;
  logic             eret_seen_r;
  logic [N_SRC-1:0] src_prev_r;
  logic [N_SRC-1:0] pending_r;
  logic [N_SRC-1:0] mask_r;
  logic [2:0]       cause_r;
  logic             ir_req_r;
  logic             busy_r;

  // Next-state values.
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] pulse_cnt_nxt_s;
  logic [CNT_W-1:0] low_cnt_nxt_s;
  logic             eret_seen_nxt_s;
  logic [2:0]       cause_nxt_s;
  logic [N_SRC-1:0] disp_clr_s;
  logic [N_SRC-1:0] new_edge_s;
  logic [N_SRC-1:0] user_clr_s;
  logic [N_SRC-1:0] active_s;
  logic [N_SRC-1:0] pending_nxt_s;

  // Edge detection, dispatch candidates and pending update (set beats clear).
  always_comb begin
    new_edge_s    = src_irq & ~src_prev_r;
    user_clr_s    = clr_we ? clr_data : SRC_ZERO;
    active_s      = pending_r & mask_r;
    pending_nxt_s = (pending_r & ~user_clr_s & ~disp_clr_s) | new_edge_s;
  end

  // Controller next-state logic.
  always_comb begin
    state_nxt_s     = state_r;
    pulse_cnt_nxt_s = pulse_cnt_r;
    low_cnt_nxt_s   = low_cnt_r;
    eret_seen_nxt_s = eret_seen_r;
    cause_nxt_s     = cause_r;
    disp_clr_s      = SRC_ZERO;
    case (state_r)
      ST_IDLE: begin
        if (|active_s) begin
          state_nxt_s     = ST_ASSERT;
          cause_nxt_s     = lowest_idx(active_s);
          disp_clr_s      = SRC_LSB << lowest_idx(active_s);
          pulse_cnt_nxt_s = CNT_ZERO;
          eret_seen_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (pulse_cnt_r == PULSE_LAST) begin
          pulse_cnt_nxt_s = CNT_ZERO;
          eret_seen_nxt_s = 1'b0;
          // An ERET that arrived during the pulse skips SERVICE entirely.
          if (eret_seen_r || eret) begin
            state_nxt_s   = ST_RECOVER;
            low_cnt_nxt_s = CNT_ZERO;
          end else begin
            state_nxt_s = ST_SERVICE;
          end
        end else begin
          pulse_cnt_nxt_s = pulse_cnt_r + CNT_ONE;
          if (eret) begin
            eret_seen_nxt_s = 1'b1;
          end else begin
            eret_seen_nxt_s = eret_seen_r;
          end
        end
      end
      ST_SERVICE: begin
        if (eret) begin
          state_nxt_s   = ST_RECOVER;
          low_cnt_nxt_s = CNT_ZERO;
        end else begin
          state_nxt_s = ST_SERVICE;
        end
      end
      ST_RECOVER: begin
        if (low_cnt_r == LOW_LAST) begin
          state_nxt_s   = ST_IDLE;
          low_cnt_nxt_s = CNT_ZERO;
        end else begin
          low_cnt_nxt_s = low_cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        pulse_cnt_nxt_s = CNT_ZERO;
        low_cnt_nxt_s   = CNT_ZERO;
        eret_seen_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset also re-samples the
  // source lines so a line already high produces no edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      pulse_cnt_r <= CNT_ZERO;
      low_cnt_r   <= CNT_ZERO;
      eret_seen_r <= 1'b0;
      src_prev_r  <= src_irq;
      pending_r   <= SRC_ZERO;
      mask_r      <= SRC_ONES;
      cause_r     <= 3'd0;
      ir_req_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pulse_cnt_r <= pulse_cnt_nxt_s;
      low_cnt_r   <= low_cnt_nxt_s;
      eret_seen_r <= eret_seen_nxt_s;
      src_prev_r  <= src_irq;
      pending_r   <= pending_nxt_s;
      mask_r      <= mask_we ? mask_wdata : mask_r;
      cause_r     <= cause_nxt_s;
      ir_req_r    <= (state_nxt_s == ST_ASSERT);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign ir_req   = ir_req_r;
  assign cause_id = cause_r;
  assign pending  = pending_r;
  assign mask     = mask_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_source_ctrl
//
// Directed bench for irq_source_ctrl with default parameters. Expected
// dispatch indices are queued when a source edge is driven and popped when
// ir_req rises; all other checks compare against constants derived from the
// intended cycle behaviour.
// -----------------------------------------------------------------------------
module tb_irq_source_ctrl;

  localparam int N_SRC = 4;

  logic             clk;
  logic             rst;
  logic [N_SRC-1:0] src_irq;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic             clr_we;
  logic [N_SRC-1:0] clr_data;
  logic             eret;
  logic             ir_req;
  logic [2:0]       cause_id;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic             busy;

  int total;
  int bad;
  int exp_q[$];

  irq_source_ctrl #(.N_SRC(N_SRC), .PULSE_LEN(4), .MIN_LOW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_irq    (src_irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .clr_we     (clr_we),
    .clr_data   (clr_data),
    .eret       (eret),
    .ir_req     (ir_req),
    .cause_id   (cause_id),
    .pending    (pending),
    .mask       (mask),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ir_req must have just risen; pop the expected source index.
  task automatic expect_dispatch(input string tag);
    int e;
    ck({tag, "_ir_req"}, 32'(ir_req), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ck({tag, "_cause"}, 32'(cause_id), 32'(e));
    end else begin
      ck({tag, "_sb_underflow"}, 32'(exp_q.size()), 32'd1);
    end
  endtask

  // From ASSERT cycle 1: finish the pulse, sit in SERVICE, ERET, recover.
  task automatic pulse_and_service(input string tag);
    for (int i = 0; i < 3; i++) begin
      tick();
      ck({tag, "_pulse_hi"}, 32'(ir_req), 32'd1);
    end
    tick();
    ck({tag, "_svc_ir"}, 32'(ir_req), 32'd0);
    ck({tag, "_svc_busy"}, 32'(busy), 32'd1);
    tick();
    ck({tag, "_svc_hold"}, 32'(busy), 32'd1);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    ck({tag, "_rec1_busy"}, 32'(busy), 32'd1);
    ck({tag, "_rec1_ir"}, 32'(ir_req), 32'd0);
    tick();
    ck({tag, "_rec2_busy"}, 32'(busy), 32'd1);
    tick();
    ck({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    src_irq    = 4'b0000;
    mask_we    = 1'b0;
    mask_wdata = 4'b0000;
    clr_we     = 1'b0;
    clr_data   = 4'b0000;
    eret       = 1'b0;

    // Reset state.
    tick(); tick(); tick();
    ck("rst_ir_req", 32'(ir_req), 32'd0);
    ck("rst_busy", 32'(busy), 32'd0);
    ck("rst_cause", 32'(cause_id), 32'd0);
    ck("rst_pending", 32'(pending), 32'h0);
    ck("rst_mask", 32'(mask), 32'hF);
    rst = 1'b1;
    tick();

    // Single source 2: pending after edge k, ir_req after k+1.
    src_irq = 4'b0100;
    exp_q.push_back(2);
    tick();
    ck("s2_pending_set", 32'(pending), 32'h4);
    ck("s2_ir_low", 32'(ir_req), 32'd0);
    tick();
    expect_dispatch("s2");
    ck("s2_pending_clr", 32'(pending), 32'h0);
    src_irq = 4'b0000;
    pulse_and_service("s2");

    // Simultaneous sources 1 and 3: lowest first, then gap, then 3.
    src_irq = 4'b1010;
    exp_q.push_back(1);
    exp_q.push_back(3);
    tick();
    ck("s13_pending", 32'(pending), 32'hA);
    tick();
    expect_dispatch("s13_first");
    ck("s13_pending_left", 32'(pending), 32'h8);
    src_irq = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    tick();
    ck("s13_svc_ir", 32'(ir_req), 32'd0);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    ck("s13_gap1", 32'(ir_req), 32'd0);
    tick();
    ck("s13_gap2", 32'(ir_req), 32'd0);
    tick();
    ck("s13_gap_idle", 32'(ir_req), 32'd0);
    ck("s13_gap_busy", 32'(busy), 32'd0);
    tick();
    expect_dispatch("s13_second");
    ck("s13_pending_empty", 32'(pending), 32'h0);
    pulse_and_service("s13");

    // Masked source 0 is retained, dispatched once unmasked.
    mask_we    = 1'b1;
    mask_wdata = 4'b1110;
    tick();
    mask_we = 1'b0;
    ck("m_mask_load", 32'(mask), 32'hE);
    src_irq = 4'b0001;
    tick();
    ck("m_pending", 32'(pending), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      ck("m_ir_blocked", 32'(ir_req), 32'd0);
    end
    ck("m_retained", 32'(pending), 32'h1);
    exp_q.push_back(0);
    mask_we    = 1'b1;
    mask_wdata = 4'b1111;
    tick();
    mask_we = 1'b0;
    ck("m_mask_full", 32'(mask), 32'hF);
    ck("m_not_yet", 32'(ir_req), 32'd0);
    tick();
    expect_dispatch("m");
    src_irq = 4'b0000;
    pulse_and_service("m");

    // ERET during the 2nd ASSERT cycle: full pulse, RECOVER, IDLE.
    src_irq = 4'b0100;
    exp_q.push_back(2);
    tick();
    tick();
    expect_dispatch("e");
    src_irq = 4'b0000;
    tick();
    ck("e_cycle2", 32'(ir_req), 32'd1);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    ck("e_cycle3", 32'(ir_req), 32'd1);
    tick();
    ck("e_cycle4", 32'(ir_req), 32'd1);
    tick();
    ck("e_rec1_ir", 32'(ir_req), 32'd0);
    ck("e_rec1_busy", 32'(busy), 32'd1);
    tick();
    ck("e_rec2_busy", 32'(busy), 32'd1);
    tick();
    ck("e_idle_busy", 32'(busy), 32'd0);
    ck("e_cause_hold", 32'(cause_id), 32'd2);

    // Set wins over a same-edge clear; plain clear still works.
    mask_we    = 1'b1;
    mask_wdata = 4'b1101;
    tick();
    mask_we  = 1'b0;
    src_irq  = 4'b0010;
    clr_we   = 1'b1;
    clr_data = 4'b0010;
    tick();
    ck("c_set_wins", 32'(pending), 32'h2);
    tick();
    clr_we = 1'b0;
    ck("c_clear", 32'(pending), 32'h0);
    mask_we    = 1'b1;
    mask_wdata = 4'b1111;
    tick();
    mask_we = 1'b0;
    tick();
    ck("c_no_dispatch", 32'(busy), 32'd0);
    src_irq = 4'b0000;

    // Source held high through reset release produces no edge.
    rst     = 1'b0;
    src_irq = 4'b0001;
    tick(); tick();
    rst = 1'b1;
    tick();
    ck("r_held_pending", 32'(pending), 32'h0);
    tick();
    ck("r_held_ir", 32'(ir_req), 32'd0);
    ck("r_held_busy", 32'(busy), 32'd0);
    src_irq = 4'b0000;
    tick();

    // Reset in the 3rd ASSERT cycle drops ir_req on that edge.
    src_irq = 4'b1000;
    exp_q.push_back(3);
    tick();
    tick();
    expect_dispatch("ra");
    tick();
    tick();
    ck("ra_cycle3", 32'(ir_req), 32'd1);
    rst = 1'b0;
    tick();
    ck("ra_ir_drop", 32'(ir_req), 32'd0);
    ck("ra_busy", 32'(busy), 32'd0);
    ck("ra_cause", 32'(cause_id), 32'd0);
    rst     = 1'b1;
    src_irq = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      ck("ra_no_residual", 32'(ir_req), 32'd0);
    end
    ck("ra_pending", 32'(pending), 32'h0);
    ck("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
